// File: rtl/demux_1to8_stream_if.sv
// Stream bundle for the 1-to-8 demultiplexer: one input stream and eight output channels.
interface demux_1to8_stream_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 16;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic [N_CH-1:0]         out_valid;
    logic [N_CH-1:0]         out_ready;
    logic [N_CH*WIDTH-1:0]   out_data;
    logic [CNT_W-1:0]        beat_cnt;

    // Producer/consumer side of the block
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, beat_cnt
    );

    // The demultiplexer itself
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, beat_cnt
    );
endinterface

// File: rtl/demux_1to8_stream.sv
// Registered 1-to-8 stream demultiplexer with unicast/broadcast routing,
// one holding register per output channel and a wrapping accepted-beat counter.
module demux_1to8_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1to8_stream_if.slave   bus
);
    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 16;

    logic [N_CH-1:0]        can_take_c;
    logic [N_CH-1:0]        load_c;
    logic [N_CH-1:0]        pop_c;
    logic                   accept_c;
    logic                   in_ready_c;

    logic [N_CH-1:0]        valid_q;
    logic [N_CH*WIDTH-1:0]  data_q;
    logic [CNT_W-1:0]       cnt_q;

    // Channel availability, input handshake and per-channel load/pop decode
    always_comb begin
        can_take_c = '0;
        load_c     = '0;
        pop_c      = '0;
        in_ready_c = 1'b0;
        accept_c   = 1'b0;

        can_take_c = ~valid_q | bus.out_ready;
        pop_c      = valid_q & bus.out_ready;

        // A broadcast needs every channel free so delivery is all-or-nothing
        if (bus.in_bcast) begin
            in_ready_c = &can_take_c;
        end else begin
            in_ready_c = can_take_c[bus.in_sel];
        end

        accept_c = bus.in_valid & in_ready_c;

        for (int i = 0; i < int'(N_CH); i++) begin
            load_c[i] = accept_c & (bus.in_bcast | (bus.in_sel == SEL_W'(i)));
        end
    end

    // Channel valid flags: a load in the same cycle as a pop keeps the channel full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (load_c[i]) begin
                    valid_q[i] <= 1'b1;
                end else if (pop_c[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Channel data words: only updated on load, otherwise keep the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (load_c[i]) begin
                    data_q[i*WIDTH +: WIDTH] <= bus.in_data;
                end
            end
        end
    end

    // Accepted-beat counter; a broadcast counts once and the counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1to8_stream.sv
// Directed self-checking bench for demux_1to8_stream.
module tb_demux_1to8_stream;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    demux_1to8_stream_if #(.WIDTH(8)) bus ();

    demux_1to8_stream #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0]  ov;
        logic [63:0] od;
        logic [15:0] bc;
        logic        rdy;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_bcast  = 1'b0;
        bus.out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        ov = bus.out_valid; od = bus.out_data; bc = bus.beat_cnt; rdy = bus.in_ready;
        n_checks++; if (ov !== 8'h00) $display("FAIL reset_out_valid: got %h want 00", ov); else n_pass++;
        n_checks++; if (od !== 64'h0) $display("FAIL reset_out_data: got %h want 0", od); else n_pass++;
        n_checks++; if (bc !== 16'h0) $display("FAIL reset_beat_cnt: got %h want 0000", bc); else n_pass++;
        n_checks++; if (rdy !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rdy); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_unicast();
        logic [7:0] exp_d;
        logic [7:0] exp_v;
        bus.out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            exp_d        = 8'(8'h11 * (i + 1));
            exp_v        = 8'(1 << i);
            bus.in_valid = 1'b1;
            bus.in_bcast = 1'b0;
            bus.in_sel   = 3'(i);
            bus.in_data  = exp_d;
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL uni_in_ready ch%0d: got %b want 1", i, bus.in_ready); else n_pass++;
            step();
            n_checks++; if (bus.out_valid !== exp_v) $display("FAIL uni_out_valid ch%0d: got %h want %h", i, bus.out_valid, exp_v); else n_pass++;
            n_checks++; if (bus.out_data[i*8 +: 8] !== exp_d) $display("FAIL uni_out_data ch%0d: got %h want %h", i, bus.out_data[i*8 +: 8], exp_d); else n_pass++;
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL uni_drain: got %h want 00", bus.out_valid); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd8) $display("FAIL uni_beat_cnt: got %0d want 8", bus.beat_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 8'hF7;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b0;
        bus.in_sel    = 3'd3;
        bus.in_data   = 8'hA5;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b want 1", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_valid !== 8'h08) $display("FAIL bp_first_valid: got %h want 08", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data[31:24] !== 8'hA5) $display("FAIL bp_first_data: got %h want a5", bus.out_data[31:24]); else n_pass++;
        bus.in_data = 8'h5A;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_blocked_ready: got %b want 0", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_data[31:24] !== 8'hA5) $display("FAIL bp_blocked_hold: got %h want a5", bus.out_data[31:24]); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd9) $display("FAIL bp_blocked_cnt: got %0d want 9", bus.beat_cnt); else n_pass++;
        bus.in_sel  = 3'd5;
        bus.in_data = 8'h3C;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_other_ready: got %b want 1", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_valid !== 8'h28) $display("FAIL bp_other_valid: got %h want 28", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data[47:40] !== 8'h3C) $display("FAIL bp_other_data: got %h want 3c", bus.out_data[47:40]); else n_pass++;
        bus.in_sel    = 3'd3;
        bus.in_data   = 8'h5A;
        bus.out_ready = 8'hFF;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_valid !== 8'h08) $display("FAIL bp_release_valid: got %h want 08", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data[31:24] !== 8'h5A) $display("FAIL bp_release_data: got %h want 5a", bus.out_data[31:24]); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd11) $display("FAIL bp_release_cnt: got %0d want 11", bus.beat_cnt); else n_pass++;
        bus.in_valid = 1'b0;
        step();
        n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL bp_drain: got %h want 00", bus.out_valid); else n_pass++;
    endtask

    task automatic test_broadcast();
        bus.out_ready = 8'hBF;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b0;
        bus.in_sel    = 3'd6;
        bus.in_data   = 8'h66;
        step();
        n_checks++; if (bus.out_valid !== 8'h40) $display("FAIL bc_fill_valid: got %h want 40", bus.out_valid); else n_pass++;
        bus.in_bcast = 1'b1;
        bus.in_sel   = 3'd0;
        bus.in_data  = 8'hC3;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bc_blocked_ready: got %b want 0", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_valid !== 8'h40) $display("FAIL bc_blocked_valid: got %h want 40", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data[7:0] !== 8'h11) $display("FAIL bc_no_partial_ch0: got %h want 11", bus.out_data[7:0]); else n_pass++;
        n_checks++; if (bus.out_data[55:48] !== 8'h66) $display("FAIL bc_no_partial_ch6: got %h want 66", bus.out_data[55:48]); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd12) $display("FAIL bc_blocked_cnt: got %0d want 12", bus.beat_cnt); else n_pass++;
        bus.out_ready = 8'hFF;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bc_release_ready: got %b want 1", bus.in_ready); else n_pass++;
        step();
        n_checks++; if (bus.out_valid !== 8'hFF) $display("FAIL bc_all_valid: got %h want ff", bus.out_valid); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.out_data[i*8 +: 8] !== 8'hC3) $display("FAIL bc_data ch%0d: got %h want c3", i, bus.out_data[i*8 +: 8]); else n_pass++;
        end
        n_checks++; if (bus.beat_cnt !== 16'd13) $display("FAIL bc_cnt: got %0d want 13", bus.beat_cnt); else n_pass++;
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        step();
        n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL bc_drain: got %h want 00", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev;
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b0;
        bus.in_sel    = 3'd2;
        for (int k = 0; k < 6; k++) begin
            prev        = 8'(8'h20 + k);
            bus.in_data = prev;
            step();
            n_checks++; if (bus.out_valid !== 8'h04) $display("FAIL b2b_valid beat%0d: got %h want 04", k, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_data[23:16] !== prev) $display("FAIL b2b_data beat%0d: got %h want %h", k, bus.out_data[23:16], prev); else n_pass++;
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL b2b_drain: got %h want 00", bus.out_valid); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd19) $display("FAIL b2b_cnt: got %0d want 19", bus.beat_cnt); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b0;
        bus.in_sel    = 3'd1;
        bus.in_data   = 8'h77;
        repeat (65535) @(posedge clk);
        #1;
        n_checks++; if (bus.beat_cnt !== 16'hFFFF) $display("FAIL wrap_max: got %h want ffff", bus.beat_cnt); else n_pass++;
        step();
        n_checks++; if (bus.beat_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", bus.beat_cnt); else n_pass++;
        step();
        n_checks++; if (bus.beat_cnt !== 16'h0001) $display("FAIL wrap_one: got %h want 0001", bus.beat_cnt); else n_pass++;
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        logic [7:0] chans [3];
        chans[0] = 8'd0; chans[1] = 8'd4; chans[2] = 8'd7;
        bus.out_ready = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_sel  = 3'(chans[k]);
            bus.in_data = 8'(8'h10 * (chans[k] + 1));
            step();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 8'h91) $display("FAIL mr_filled: got %h want 91", bus.out_valid); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd4) $display("FAIL mr_cnt_before: got %0d want 4", bus.beat_cnt); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL mr_valid: got %h want 00", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 64'h0) $display("FAIL mr_data: got %h want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'h0) $display("FAIL mr_cnt: got %h want 0000", bus.beat_cnt); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mr_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        #2;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd0;
        bus.in_data  = 8'hE1;
        step();
        n_checks++; if (bus.out_valid !== 8'h01) $display("FAIL mr_after_valid: got %h want 01", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data[7:0] !== 8'hE1) $display("FAIL mr_after_data: got %h want e1", bus.out_data[7:0]); else n_pass++;
        n_checks++; if (bus.beat_cnt !== 16'd1) $display("FAIL mr_after_cnt: got %0d want 1", bus.beat_cnt); else n_pass++;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_back_to_back();
        test_counter_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_1to8_stream.md
# demux_1to8_stream

Registered 1-to-8 stream demultiplexer: accepts one beat per cycle on a valid/ready input and routes it to one of eight output channels selected by a 3-bit code, or to all eight at once in broadcast mode. Select encoding matches the 8:1 mux: code 000 selects channel 0 (A), through 111, which selects channel 7 (H). Each channel holds one beat in an output register with its own valid/ready handshake, so a stalled consumer never blocks traffic to the other channels. A wrapping counter records accepted beats for debug.

## Interface
- WIDTH, 8, data width of one beat
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the beat this cycle
- in_data  input  WIDTH  input payload
- in_sel  input  3  destination channel, 000→ch0 … 111→ch7; ignored when in_bcast=1
- in_bcast  input  1  deliver the beat to all 8 channels
- out_valid  output  8  per-channel beat held, bit i = channel i
- out_ready  input  8  per-channel consumer ready
- out_data  output  8*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
- beat_cnt  output  16  number of accepted input beats, wraps modulo 2^16

## Operation
- Each channel i has a one-entry register: a valid flag (out_valid[i]) and a data word.
- Channel i can take a beat this cycle (can_take[i]) when out_valid[i]=0 or out_ready[i]=1. This allows a pop and a push in the same cycle.
- in_ready for unicast (in_bcast=0): can_take[in_sel].
- in_ready for broadcast (in_bcast=1): AND of can_take[7:0].
- in_ready is combinational from out_valid, out_ready, in_sel and in_bcast. It never depends on in_valid.
- An input beat is accepted when in_valid & in_ready.
- Unicast accept: channel in_sel loads in_data and sets valid.
- Broadcast accept: all eight channels load in_data and set valid in the same cycle. There is no partial delivery: if any channel cannot take the beat, no channel loads.
- Output pop: when out_valid[i] & out_ready[i], channel i clears valid, unless the same cycle also loads it. Load wins, and valid stays 1 with the new data.
- out_data[i] holds its value while out_valid[i]=1. Once channel i has been popped and not reloaded, out_data[i] keeps its last value.
- beat_cnt increments by 1 per accepted beat. A broadcast counts as one beat. 0xFFFF wraps to 0x0000.
- The input side must hold in_valid, in_data, in_sel and in_bcast stable until accepted. The block does not check this.

## Timing
- Reset (rst_n=0, asynchronous assert): out_valid=8'h00, out_data=all zeros, beat_cnt=0, in_ready combinational. In practice in_ready=1 during reset, since all channels are empty.
- Reset release: synchronous to clk. The first accept is possible on the first rising edge with rst_n=1.
- Reset mid-operation: all held beats are discarded and the counter clears. No output handshake completes in the reset cycle.
- Latency: a beat accepted at edge N is visible on out_valid/out_data right after edge N, i.e. one cycle.
- Throughput: one beat per cycle per the input. A channel whose consumer holds out_ready=1 sustains one beat per cycle.
- Full channel, out_ready=0: in_ready=0 for a unicast to that channel, and for any broadcast. Other channels remain reachable.
- Simultaneous pop of channel i and accept to channel i: new data is registered and out_valid[i] stays 1 with no bubble.
- Simultaneous pop of channel j and accept to channel i≠j: both complete independently.
- in_sel changes while in_valid=0: no effect.

## Test plan
- Reset then unicast: after reset, send 0x11…0x88 with in_sel 0…7 back to back, all out_ready=1 → in_ready=1 throughout; out_valid[i] pulses for one cycle carrying 0x11*(i+1) one cycle after each accept; beat_cnt=8.
- Backpressure isolation: out_ready[3]=0, send 0xA5 to ch3, then 0x5A to ch3, then 0x3C to ch5 → first beat accepted; in_ready=0 for the second; after in_sel switches to 5, 0x3C is accepted and out_valid=8'h28. Raising out_ready[3] lets 0x5A through with no bubble.
- Broadcast blocking: ch6 full, out_ready[6]=0, in_bcast=1 with 0xC3 → in_ready=0 and no channel loads. Raising out_ready[6] accepts the beat: out_valid=8'hFF, every out_data slice=0xC3, beat_cnt +1.
- Same-cycle pop/push on ch2 with out_ready[2]=1 and continuous unicast to ch2 → out_valid[2] stays 1 for the whole burst; each cycle's data equals the prior cycle's input.
- Counter wrap: accept 65537 beats → beat_cnt=0x0001.
- Mid-operation reset: three channels full; assert rst_n low between edges → out_valid, out_data and beat_cnt are 0 immediately, before the next edge. After release, the next beat to ch0 appears one cycle later.
